// File: rtl/hex_ascii_streamer.sv
// Captures NUM_BYTES of ID/status data on start and streams it as space-separated upper-case hex
// text, one character per valid/ready handshake, padded to a full LCD frame. HEX_PREFIX_EN adds "0x".
module hex_ascii_streamer #(
    parameter int          NUM_BYTES   = 3,
    parameter int          LINE_CHARS  = 16,
    parameter int          NUM_LINES   = 2,
    parameter logic [7:0]  SEP_CHAR    = 8'h20,
    parameter logic [7:0]  PAD_CHAR    = 8'h20,
    localparam int         TOTAL_CHARS = LINE_CHARS * NUM_LINES,
    localparam int         IDX_W       = (TOTAL_CHARS > 1) ? $clog2(TOTAL_CHARS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8*NUM_BYTES-1:0]   data_in,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               char_out,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic [IDX_W-1:0]         char_index,
    output logic [8*TOTAL_CHARS-1:0] ascii_string
);

`ifdef HEX_PREFIX_EN
    localparam int CHARS_PER_BYTE = 5;
`else
    localparam int CHARS_PER_BYTE = 3;
`endif
    localparam int               CONTENT_LEN = CHARS_PER_BYTE * NUM_BYTES - 1;
    // Position of the high digit inside one byte's character group.
    localparam int               DIGIT_OFS   = CHARS_PER_BYTE - 3;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TOTAL_CHARS - 1);

    if (CONTENT_LEN > TOTAL_CHARS) begin : g_len_check
        $error("hex_ascii_streamer: rendered content does not fit in the LCD frame");
    end

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic [8*NUM_BYTES-1:0]   data_q, data_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [8*TOTAL_CHARS-1:0] frame_q, frame_d;
    logic [7:0]               cur_char;

    function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] pos,
                                           input logic [8*NUM_BYTES-1:0] data);
        int                     p;
        int                     k;
        int                     off;
        logic [8*NUM_BYTES-1:0] sh;
        logic [7:0]             b;
        p   = int'(pos);
        k   = p / CHARS_PER_BYTE;
        off = p % CHARS_PER_BYTE;
        sh  = data << (8 * k);
        b   = sh[8*NUM_BYTES-1 -: 8];
        if (p >= CONTENT_LEN)          return PAD_CHAR;
        if (off == DIGIT_OFS)          return nibble_ascii(b[7:4]);
        if (off == DIGIT_OFS + 1)      return nibble_ascii(b[3:0]);
        if (off == CHARS_PER_BYTE - 1) return SEP_CHAR;
        if (off == 0)                  return 8'h30;
        return 8'h78;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        cur_char = char_at(idx_q, data_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    idx_d   = '0;
                    frame_d = {TOTAL_CHARS{PAD_CHAR}};
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    for (int i = 0; i < TOTAL_CHARS; i++) begin
                        if (idx_q == IDX_W'(i)) frame_d[8*(TOTAL_CHARS-1-i) +: 8] = cur_char;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            // NOTE: the frame buffer is a visible output, so unlike a plain memory it is reset to blanks.
            frame_q <= {TOTAL_CHARS{8'h20}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign char_valid   = (state_q == S_EMIT);
    assign char_out     = char_valid ? cur_char : 8'h00;
    assign char_index   = idx_q;
    assign ascii_string = frame_q;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer: a 3-byte and a wider instance share clock, reset and ready.
// Expected text is hand-written per vector; HEX_PREFIX_EN selects the prefixed expectations.
module tb_hex_ascii_streamer;

    localparam int TOTAL = 32;
`ifdef HEX_PREFIX_EN
    localparam int NB8 = 6;
`else
    localparam int NB8 = 8;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start3, start8, ready;
    logic [23:0]      d3;
    logic [8*NB8-1:0] d8;

    logic busy3, done3, valid3, busy8, done8, valid8;
    logic [7:0]   char3, char8;
    logic [4:0]   idx3, idx8;
    logic [255:0] ascii3, ascii8;

    bit           sel;
    logic         o_busy, o_done, o_valid;
    logic [7:0]   o_char;
    logic [4:0]   o_idx;
    logic [255:0] o_ascii;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hex_ascii_streamer #(.NUM_BYTES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .data_in(d3), .busy(busy3), .done(done3),
        .char_out(char3), .char_valid(valid3), .char_ready(ready), .char_index(idx3),
        .ascii_string(ascii3)
    );

    hex_ascii_streamer #(.NUM_BYTES(NB8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(d8), .busy(busy8), .done(done8),
        .char_out(char8), .char_valid(valid8), .char_ready(ready), .char_index(idx8),
        .ascii_string(ascii8)
    );

    assign o_busy  = sel ? busy8  : busy3;
    assign o_done  = sel ? done8  : done3;
    assign o_valid = sel ? valid8 : valid3;
    assign o_char  = sel ? char8  : char3;
    assign o_idx   = sel ? idx8   : idx3;
    assign o_ascii = sel ? ascii8 : ascii3;

    typedef struct {
        bit           s;
        logic [63:0]  din;
        logic [255:0] txt;
        int           len;
        bit           rnd;
        bit           repulse;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit s, input logic [63:0] din, input logic [255:0] txt,
                                input int len, input bit rnd, input bit rp);
        vec_t v;
        v.s = s; v.din = din; v.txt = txt; v.len = len; v.rnd = rnd; v.repulse = rp;
        return v;
    endfunction

    // Left-justify the content literal and fill the tail of the frame with blanks.
    function automatic logic [255:0] frame_of(input logic [255:0] txt, input int len);
        logic [255:0] f;
        f = txt << (8 * (TOTAL - len));
        for (int i = 0; i < TOTAL - len; i++) f[8*i +: 8] = 8'h20;
        return f;
    endfunction

    task automatic drive_start(input bit s, input logic [63:0] din);
        if (s) begin
            d8     = din[8*NB8-1:0];
            start8 = 1'b1;
        end else begin
            d3     = din[23:0];
            start3 = 1'b1;
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic [255:0] exp;
        logic [7:0]   e;
        int           n, cyc, last_hs, done_cyc, bad;
        bit           seen_done;
        exp       = frame_of(v.txt, v.len);
        n         = 0;
        last_hs   = -1;
        done_cyc  = -1;
        bad       = 0;
        seen_done = 1'b0;
        @(negedge clk);
        sel   = v.s;
        ready = 1'b1;
        drive_start(v.s, v.din);
        @(negedge clk);
        cyc = 1;
        while (!seen_done && cyc <= 1000) begin
            start3 = 1'b0;
            start8 = 1'b0;
            ready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.repulse && cyc == 5) drive_start(v.s, ~v.din);
            if (cyc == 1) check("frame cleared on start", o_ascii, {TOTAL{8'h20}});
            if (o_done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check("valid low on done", 256'(o_valid), 256'(0));
                check("busy high on done", 256'(o_busy), 256'(1));
                check("done follows last handshake", 256'(cyc), 256'(last_hs + 1));
                check("frame buffer", o_ascii, exp);
                if (v.repulse) drive_start(v.s, v.din);
            end else if (o_valid && n < TOTAL) begin
                e = exp[8*(TOTAL-1-n) +: 8];
                check($sformatf("char_out at %0d", n), 256'(o_char), 256'(e));
                check($sformatf("char_index at %0d", n), 256'(o_idx), 256'(n));
                if (ready) begin
                    n++;
                    last_hs = cyc;
                end
            end else begin
                bad++;
            end
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen_done) check("done timeout", 256'(0), 256'(1));
        check("handshake count", 256'(n), 256'(TOTAL));
        check("cycles without valid or done", 256'(bad), 256'(0));
        if (!v.rnd) check("done at start+33", 256'(done_cyc), 256'(TOTAL + 1));
        @(negedge clk);
        start3 = 1'b0;
        start8 = 1'b0;
        check("idle after done", {o_busy, o_done, o_valid}, 256'(0));
        @(negedge clk);
        check("no restart from ignored start", 256'(o_busy), 256'(0));
    endtask

    initial begin
        int done_seen;
        int guard;
        start3 = 1'b0;
        start8 = 1'b0;
        ready  = 1'b0;
        d3     = '0;
        d8     = '0;
        sel    = 1'b0;

`ifdef HEX_PREFIX_EN
        vecs[0] = mk(1'b0, 64'h202015, "0x20 0x20 0x15", 14, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 64'h89ABCDEF0123, "0x89 0xAB 0xCD 0xEF 0x01 0x23", 29, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 64'hA5F00E, "0xA5 0xF0 0x0E", 14, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 64'h9C3B7D, "0x9C 0x3B 0x7D", 14, 1'b0, 1'b1);
`else
        vecs[0] = mk(1'b0, 64'h202015, "20 20 15", 8, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 64'h0123456789ABCDEF, "01 23 45 67 89 AB CD EF", 23, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 64'hA5F00E, "A5 F0 0E", 8, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 64'h9C3B7D, "9C 3B 7D", 8, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("reset busy/done/valid (3-byte)", {busy3, done3, valid3}, 256'(0));
        check("reset char_out/index (3-byte)", {char3, idx3}, 256'(0));
        check("reset frame (3-byte)", ascii3, {TOTAL{8'h20}});
        check("reset state (wide)", {busy8, done8, valid8, char8, idx8}, 256'(0));
        check("reset frame (wide)", ascii8, {TOTAL{8'h20}});
        rst   = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ready ignored while idle", {busy3, valid3, busy8, valid8}, 256'(0));
        ready = 1'b0;

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Abort mid-frame: reset at char_index 10, then confirm no done and a clean restart.
        @(negedge clk);
        sel    = 1'b0;
        ready  = 1'b1;
        d3     = 24'h123456;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        guard  = 0;
        while (!(valid3 && idx3 == 5'd10) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reached char_index 10", 256'(idx3), 256'(10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy/done/valid", {busy3, done3, valid3}, 256'(0));
        check("abort char_out/index", {char3, idx3}, 256'(0));
        check("abort frame blank", ascii3, {TOTAL{8'h20}});
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done3 || busy3) done_seen++;
        end
        check("no done or activity after abort", 256'(done_seen), 256'(0));

        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
